// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the sequential fixed-point multiplier:
//   - default operand width and fractional-bit count (unsigned Q6.4)
//   - number of shift-add iterations per multiply
//   - controller state encoding
//   - helper for sizing the iteration counter
// ---------------------------------------------------------------------------
package mult_pkg;

   localparam int DEF_WIDTH = 10;
   localparam int DEF_FRAC  = 4;

   // One shift-add step per multiplier bit, so a multiply always takes
   // exactly DEF_WIDTH calculation cycles regardless of operand values.
   localparam int DEF_ITERS = DEF_WIDTH;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CALC = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Counter width able to hold 0..width-1 (at least one bit).
   function automatic int cnt_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/mult_datapath.sv
// ---------------------------------------------------------------------------
// mult_datapath
// Operand registers, 2*WIDTH-bit shift-add accumulator and the registered
// result/overflow outputs of the fixed-point multiplier.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   load_en    in   capture a_in/b_in, clear accumulator
//   step_en    in   perform one shift-add step
//   finish_en  in   last step: also register the scaled product and overflow
//   a_in       in   [WIDTH-1:0] multiplicand
//   b_in       in   [WIDTH-1:0] multiplier
//   q_out      out  [WIDTH-1:0] product[WIDTH+FRAC-1:FRAC]
//   ovf_out    out  OR of product bits above the result window
// ---------------------------------------------------------------------------
module mult_datapath
   import mult_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int FRAC  = DEF_FRAC
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load_en,
   input  logic             step_en,
   input  logic             finish_en,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic [WIDTH-1:0] q_out,
   output logic             ovf_out
);

   localparam int PW = 2 * WIDTH;

   logic [PW-1:0]    mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [PW-1:0]    acc_q, acc_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             ovf_q, ovf_d;
   logic [PW-1:0]    acc_step;

   // The final step's sum is taken straight from acc_step so the result
   // registers load on the same edge that finishes the last iteration.
   always_comb begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      q_d      = q_q;
      ovf_d    = ovf_q;
      acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

      if (load_en) begin
         mcand_d  = {{WIDTH{1'b0}}, a_in};
         mplier_d = b_in;
         acc_d    = '0;
      end

      if (step_en) begin
         acc_d    = acc_step;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
      end

      if (finish_en) begin
         q_d   = acc_step[WIDTH+FRAC-1:FRAC];
         ovf_d = |acc_step[PW-1:WIDTH+FRAC];
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         q_q      <= '0;
         ovf_q    <= 1'b0;
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         q_q      <= q_d;
         ovf_q    <= ovf_d;
      end
   end

   assign q_out   = q_q;
   assign ovf_out = ovf_q;

endmodule

// File: rtl/fixed_multiplier.sv
// ---------------------------------------------------------------------------
// fixed_multiplier
// Unsigned fixed-point sequential multiplier (shift-add, one bit per cycle).
// This level is the controller: FSM, iteration counter, busy/valid; the
// arithmetic lives in mult_datapath.
//
// Ports:
//   clock  in   rising-edge clock
//   reset  in   asynchronous active-low reset
//   start  in   begin a multiply (only looked at in IDLE)
//   A      in   [WIDTH-1:0] multiplicand
//   B      in   [WIDTH-1:0] multiplier
//   Q      out  [WIDTH-1:0] registered truncated product
//   busy   out  high in LOAD and CALC
//   ovf    out  product did not fit in WIDTH bits (held with Q)
//   valid  out  one-cycle pulse in DONE marking a new Q/ovf
// ---------------------------------------------------------------------------
module fixed_multiplier
   import mult_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int FRAC  = DEF_FRAC
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] Q,
   output logic             busy,
   output logic             ovf,
   output logic             valid
);

   localparam int              CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             load_en;
   logic             step_en;
   logic             finish_en;

   // Next-state logic. CALC always runs all WIDTH steps; there is no early
   // exit on zero operands so latency is fixed.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      load_en   = 1'b0;
      step_en   = 1'b0;
      finish_en = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            load_en = 1'b1;
            cnt_d   = '0;
            state_d = ST_CALC;
         end
         ST_CALC: begin
            step_en = 1'b1;
            if (cnt_q == LAST) begin
               finish_en = 1'b1;
               state_d   = ST_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy  = (state_q == ST_LOAD) || (state_q == ST_CALC);
   assign valid = (state_q == ST_DONE);

   mult_datapath #(
      .WIDTH (WIDTH),
      .FRAC  (FRAC)
   ) u_datapath (
      .clock     (clock),
      .reset     (reset),
      .load_en   (load_en),
      .step_en   (step_en),
      .finish_en (finish_en),
      .a_in      (A),
      .b_in      (B),
      .q_out     (Q),
      .ovf_out   (ovf)
   );

endmodule

// File: tb/tb_fixed_multiplier.sv
// ---------------------------------------------------------------------------
// tb_fixed_multiplier
// Scoreboard bench for fixed_multiplier (WIDTH=10, FRAC=4). Stimulus pushes
// the hand-computed result and the cycle in which valid must appear; an
// independent monitor pops and compares on every valid pulse, and also
// checks that each operation was preceded by exactly 11 busy cycles.
// ---------------------------------------------------------------------------
module tb_fixed_multiplier;

   localparam int WIDTH = 10;
   localparam int FRAC  = 4;

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic             start = 1'b0;
   logic [WIDTH-1:0] A = '0;
   logic [WIDTH-1:0] B = '0;
   logic [WIDTH-1:0] Q;
   logic             busy;
   logic             ovf;
   logic             valid;

   typedef struct {
      logic [WIDTH-1:0] q;
      logic             ovf;
      int               cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   cyc      = 0;
   int   checks   = 0;
   int   passes   = 0;
   int   busy_run = 0;

   fixed_multiplier #(
      .WIDTH (WIDTH),
      .FRAC  (FRAC)
   ) dut (
      .clock (clock),
      .reset (reset),
      .start (start),
      .A     (A),
      .B     (B),
      .Q     (Q),
      .busy  (busy),
      .ovf   (ovf),
      .valid (valid)
   );

   // Free-running clock and a cycle counter used to time-stamp expectations.
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Watchdog so the run can never hang.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual === expected) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                  name, actual, expected, $time);
      end
   endtask

   // Monitor: runs on the falling edge, away from the active edge.
   always @(negedge clock) begin
      if (reset) begin
         if (valid) begin
            checkOutput("pending op at valid", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
               mon_e = sb.pop_front();
               checkOutput("Q", 32'(Q), 32'(mon_e.q));
               checkOutput("ovf", 32'(ovf), 32'(mon_e.ovf));
               checkOutput("valid cycle", mon_e.cyc, cyc);
            end
            checkOutput("busy length", busy_run, 11);
            busy_run = 0;
         end else if (busy) begin
            busy_run++;
         end else begin
            busy_run = 0;
         end
      end else begin
         busy_run = 0;
      end
   end

   // Raise start for one cycle with the given operands and queue the result.
   task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic [WIDTH-1:0] exp_q, input logic exp_ovf);
      exp_t e;
      @(negedge clock);
      A     = a;
      B     = b;
      start = 1'b1;
      e.q   = exp_q;
      e.ovf = exp_ovf;
      e.cyc = cyc + 12;
      sb.push_back(e);
      @(negedge clock);
      start = 1'b0;
   endtask

   // Bounded wait until the monitor has consumed every queued result.
   task automatic waitDrain(input string name);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 60) begin
         @(negedge clock);
         #1;
         n++;
      end
      checkOutput({"drained ", name}, sb.size(), 0);
   endtask

   task automatic waitValid(input string name);
      int n;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!valid && n < 40);
      checkOutput({"valid seen ", name}, 32'(valid), 1);
   endtask

   task automatic checkIdleOutputs(input string name);
      checkOutput({name, " Q"}, 32'(Q), 0);
      checkOutput({name, " ovf"}, 32'(ovf), 0);
      checkOutput({name, " valid"}, 32'(valid), 0);
      checkOutput({name, " busy"}, 32'(busy), 0);
   endtask

   initial begin
      exp_t e;
      int   base;

      // Power-up reset state
      #1;
      checkIdleOutputs("reset");
      repeat (2) @(negedge clock);
      reset = 1'b1;

      // 6.0 * 1.0 = 6.0
      applyStimulus(10'h060, 10'h010, 10'h060, 1'b0);
      waitDrain("6.0*1.0");

      // 1.5 * 1.5 = 2.25 ; 0.0625 * 0.0625 truncates to 0
      applyStimulus(10'h018, 10'h018, 10'h024, 1'b0);
      waitDrain("1.5*1.5");
      applyStimulus(10'h001, 10'h001, 10'h000, 1'b0);
      waitDrain("lsb*lsb");

      // Zero operand
      applyStimulus(10'h000, 10'h3FF, 10'h000, 1'b0);
      waitDrain("zero");

      // 50.0 * 50.0 = 640000 raw = 0x9C400 ; bits [13:4] = 0x040, overflow
      applyStimulus(10'h320, 10'h320, 10'h040, 1'b1);
      waitDrain("50*50");

      // Operand changes and a start re-pulse during CALC are ignored
      applyStimulus(10'h060, 10'h010, 10'h060, 1'b0);
      repeat (4) @(negedge clock);
      A     = 10'h3FF;
      B     = 10'h3FF;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      waitDrain("ignore in CALC");
      repeat (20) @(negedge clock);

      // Reset mid-CALC: outputs clear immediately, no valid follows
      applyStimulus(10'h320, 10'h320, 10'h040, 1'b1);
      repeat (4) @(negedge clock);
      #2;
      reset = 1'b0;
      #1;
      checkIdleOutputs("mid-CALC reset");
      sb.delete();
      repeat (3) @(negedge clock);
      reset = 1'b1;
      repeat (15) @(negedge clock);
      applyStimulus(10'h320, 10'h010, 10'h320, 1'b0);
      waitDrain("after reset");

      // start held high: three back-to-back operations, 13 cycles apart
      @(negedge clock);
      A     = 10'h018;
      B     = 10'h018;
      start = 1'b1;
      base  = cyc;
      e.q = 10'h024; e.ovf = 1'b0; e.cyc = base + 12; sb.push_back(e);
      e.q = 10'h060; e.ovf = 1'b0; e.cyc = base + 25; sb.push_back(e);
      e.q = 10'h000; e.ovf = 1'b0; e.cyc = base + 38; sb.push_back(e);
      waitValid("b2b 1");
      A = 10'h060;
      B = 10'h010;
      waitValid("b2b 2");
      A = 10'h001;
      B = 10'h001;
      @(negedge clock);
      @(negedge clock);
      start = 1'b0;
      waitDrain("back-to-back");
      repeat (20) @(negedge clock);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
